spi_frame_listener: RTL and testbench

//  Parametrised successor of the 3-byte SPI command listener. Assembles a fixed-length frame from
//  the byte stream of the SPI slave, qualifies the header byte against a masked address or broadcast

---
 rtl/spi_frame_listener_pkg.sv | 12 +
 rtl/spi_idle_timer.sv | 30 +++
 rtl/spi_frame_listener.sv | 137 +++++++++++++
 tb/tb_spi_frame_listener.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_listener_pkg.sv
// Shared types and constants for the SPI frame listener.
// Holds the FSM state encoding and the checksum seed.
package spi_frame_listener_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  localparam logic [7:0] CKSUM_SEED = 8'h00;

endpackage

// File: rtl/spi_idle_timer.sv
// Inter-byte idle counter: cleared by each byte, otherwise counts up and saturates at LIMIT.
// expired flags the cycle whose clock edge moves the count onto LIMIT, so it fires exactly once per gap.
module spi_idle_timer #(
  parameter int LIMIT = 400
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  localparam int TW = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] LIM    = TW'(LIMIT);
  localparam logic [TW-1:0] LIM_M1 = TW'(LIMIT - 1);

  logic [TW-1:0] timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (timer != LIM) begin
      timer <= timer + 1'b1;
    end
  end

  assign expired = !clear && (timer == LIM_M1);

endmodule

// File: rtl/spi_frame_listener.sv
// Assembles fixed-length frames from the spi_slave byte stream, qualifies the header
// against an address/broadcast pattern, optionally checks an XOR checksum, and aborts on idle timeout.
module spi_frame_listener
  import spi_frame_listener_pkg::*;
#(
  parameter int         FRAME_BYTES    = 3,
  parameter logic [7:0] ADDR_MATCH     = 8'h20,
  parameter logic [7:0] ADDR_MASK      = 8'hE0,
  parameter bit         BCAST_EN       = 1'b1,
  parameter int         TIMEOUT_CYCLES = 400,
  parameter bit         CKSUM_EN       = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_in,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     frame_valid,
  output logic                     frame_bcast,
  output logic                     err_timeout,
  output logic                     err_cksum
);

  localparam int FW = 8 * FRAME_BYTES;
  localparam int IW = $clog2(FRAME_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);

  state_e        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [FW-9:0] shreg;
  logic [7:0]    xor_acc;
  logic          hdr_bc;

  logic          addr_hit, bc_hit, expired, cksum_ok;
  logic          load_hdr, shift_byte, frame_ok, cksum_bad, tmo_abort;
  logic [FW-1:0] frame_asm;

  assign addr_hit  = ((byte_in ^ ADDR_MATCH) & ADDR_MASK) == 8'h00;
  assign bc_hit    = BCAST_EN && ((byte_in & ~ADDR_MASK) == 8'h00);
  assign frame_asm = {shreg, byte_in};
  assign cksum_ok  = !CKSUM_EN || ((xor_acc ^ byte_in) == 8'h00);

  spi_idle_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (byte_valid),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // A byte arriving on the expiry cycle takes priority, so the timeout is only checked without one.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    load_hdr   = 1'b0;
    shift_byte = 1'b0;
    frame_ok   = 1'b0;
    cksum_bad  = 1'b0;
    tmo_abort  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (byte_valid && (addr_hit || bc_hit)) begin
          load_hdr  = 1'b1;
          idx_nxt   = IW'(1);
          state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (byte_valid) begin
          shift_byte = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            frame_ok  = cksum_ok;
            cksum_bad = !cksum_ok;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else if (expired) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
          tmo_abort = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // shreg keeps every byte except the one currently on byte_in; the truncating cast drops the oldest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      xor_acc <= CKSUM_SEED;
      hdr_bc  <= 1'b0;
    end else if (load_hdr) begin
      shreg   <= (FW-8)'(byte_in);
      xor_acc <= CKSUM_SEED ^ byte_in;
      hdr_bc  <= bc_hit && !addr_hit;
    end else if (shift_byte) begin
      shreg   <= (FW-8)'({shreg, byte_in});
      xor_acc <= xor_acc ^ byte_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data  <= '0;
      frame_bcast <= 1'b0;
      frame_valid <= 1'b0;
      err_cksum   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      frame_valid <= frame_ok;
      err_cksum   <= cksum_bad;
      err_timeout <= tmo_abort;
      if (frame_ok) begin
        frame_data  <= frame_asm;
        frame_bcast <= hdr_bc;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_listener.sv
// Bench for spi_frame_listener: two configurations driven by directed and random byte streams,
// compared every cycle against a frame-level model built from byte lists.
module tb_spi_frame_listener;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        bv0 = 1'b0, bv1 = 1'b0;
  logic [7:0]  bi0 = 8'h00, bi1 = 8'h00;
  logic [23:0] fd0;
  logic [31:0] fd1;
  logic        fv0, fbc0, et0, ec0;
  logic        fv1, fbc1, et1, ec1;

  spi_frame_listener #(
    .FRAME_BYTES(3), .ADDR_MATCH(8'h20), .ADDR_MASK(8'hE0),
    .BCAST_EN(1'b1), .TIMEOUT_CYCLES(400), .CKSUM_EN(1'b0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .byte_valid(bv0), .byte_in(bi0),
    .frame_data(fd0), .frame_valid(fv0), .frame_bcast(fbc0),
    .err_timeout(et0), .err_cksum(ec0)
  );

  spi_frame_listener #(
    .FRAME_BYTES(4), .ADDR_MATCH(8'h20), .ADDR_MASK(8'hE0),
    .BCAST_EN(1'b0), .TIMEOUT_CYCLES(20), .CKSUM_EN(1'b1)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .byte_valid(bv1), .byte_in(bi1),
    .frame_data(fd1), .frame_valid(fv1), .frame_bcast(fbc1),
    .err_timeout(et1), .err_cksum(ec1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int cfg_fb(input int i);  return (i == 0) ? 3 : 4;    endfunction
  function automatic int cfg_tmo(input int i); return (i == 0) ? 400 : 20; endfunction
  function automatic bit cfg_cks(input int i); return (i == 1);            endfunction
  function automatic bit cfg_bc(input int i);  return (i == 0);            endfunction

  bit           mcoll [2];
  int           mlen  [2];
  int           midle [2];
  logic [7:0]   mbuf  [2][16];
  logic [127:0] mframe[2];
  bit           mbc   [2];
  bit           mhbc  [2];
  bit           mfv   [2];
  bit           met   [2];
  bit           mec   [2];

  task automatic m_reset(input int i);
    mcoll[i] = 0; mlen[i] = 0; midle[i] = 0;
    mframe[i] = '0; mbc[i] = 0; mhbc[i] = 0;
    mfv[i] = 0; met[i] = 0; mec[i] = 0;
  endtask

  task automatic m_step(input int i, input bit bv, input logic [7:0] b);
    bit addr, bc;
    logic [7:0] x;
    logic [127:0] fr;
    mfv[i] = 0; met[i] = 0; mec[i] = 0;
    if (bv) begin
      midle[i] = 0;
      if (!mcoll[i]) begin
        addr = ((b ^ 8'h20) & 8'hE0) == 8'h00;
        bc   = cfg_bc(i) && ((b & 8'h1F) == 8'h00);
        if (addr || bc) begin
          mcoll[i] = 1; mlen[i] = 1; mbuf[i][0] = b; mhbc[i] = bc && !addr;
        end
      end else begin
        mbuf[i][mlen[i]] = b;
        mlen[i]++;
        if (mlen[i] == cfg_fb(i)) begin
          mcoll[i] = 0;
          x = 8'h00; fr = '0;
          for (int k = 0; k < mlen[i]; k++) begin
            x  = x ^ mbuf[i][k];
            fr = (fr << 8) | 128'(mbuf[i][k]);
          end
          if (!cfg_cks(i) || x == 8'h00) begin
            mframe[i] = fr; mbc[i] = mhbc[i]; mfv[i] = 1;
          end else begin
            mec[i] = 1;
          end
        end
      end
    end else if (midle[i] < cfg_tmo(i)) begin
      midle[i]++;
      if (midle[i] == cfg_tmo(i) && mcoll[i]) begin
        mcoll[i] = 0; met[i] = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_reset(0); m_reset(1);
    end else begin
      m_step(0, bv0, bi0);
      m_step(1, bv1, bi1);
    end
  end

  int fvcnt0 = 0, etcnt0 = 0;

  always @(negedge clk) begin
    fvcnt0 += int'(fv0);
    etcnt0 += int'(et0);
    chk("m0_frame_data",  128'(fd0),  rst_n ? mframe[0] : 128'd0);
    chk("m0_frame_valid", 128'(fv0),  rst_n ? 128'(mfv[0]) : 128'd0);
    chk("m0_frame_bcast", 128'(fbc0), rst_n ? 128'(mbc[0]) : 128'd0);
    chk("m0_err_timeout", 128'(et0),  rst_n ? 128'(met[0]) : 128'd0);
    chk("m0_err_cksum",   128'(ec0),  rst_n ? 128'(mec[0]) : 128'd0);
    chk("m1_frame_data",  128'(fd1),  rst_n ? mframe[1] : 128'd0);
    chk("m1_frame_valid", 128'(fv1),  rst_n ? 128'(mfv[1]) : 128'd0);
    chk("m1_frame_bcast", 128'(fbc1), rst_n ? 128'(mbc[1]) : 128'd0);
    chk("m1_err_timeout", 128'(et1),  rst_n ? 128'(met[1]) : 128'd0);
    chk("m1_err_cksum",   128'(ec1),  rst_n ? 128'(mec[1]) : 128'd0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put0(input logic [7:0] b);
    bv0 = 1'b1; bi0 = b; tick(); bv0 = 1'b0;
  endtask

  task automatic put1(input logic [7:0] b);
    bv1 = 1'b1; bi1 = b; tick(); bv1 = 1'b0;
  endtask

  // Random stream entries: 0..255 is a byte, 256+n is an idle gap of n cycles.
  int rq0[$], rq1[$];
  int gap0 = 0, gap1 = 0;

  task automatic refill(input int i);
    int s[$];
    int r, fb, n;
    logic [7:0] b, x;
    fb = cfg_fb(i);
    r = $urandom_range(0, 9);
    if (r <= 5) begin
      n = (r == 5) ? $urandom_range(1, fb - 1) : fb;
      case ($urandom_range(0, 3))
        0:       b = 8'($urandom);
        1:       b = {3'b000, 5'($urandom)};
        default: b = {3'b001, 5'($urandom)};
      endcase
      x = b;
      s.push_back(int'(b));
      for (int k = 1; k < n; k++) begin
        b = 8'($urandom);
        if (k == fb - 1 && i == 1 && $urandom_range(0, 3) != 0) b = x;
        x = x ^ b;
        if ($urandom_range(0, 5) == 0) s.push_back(256 + $urandom_range(1, 3));
        s.push_back(int'(b));
      end
    end else if (r <= 7) begin
      s.push_back(int'($urandom_range(0, 255)));
    end else if (r == 8) begin
      s.push_back(256 + $urandom_range(cfg_tmo(i) - 2, cfg_tmo(i) + 2));
    end else begin
      s.push_back(256 + $urandom_range(1, 10));
    end
    foreach (s[k]) begin
      if (i == 0) rq0.push_back(s[k]);
      else        rq1.push_back(s[k]);
    end
  endtask

  task automatic drive_rand0();
    int v;
    bv0 = 1'b0;
    if (gap0 > 0) begin
      gap0--;
    end else begin
      if (rq0.size() == 0) refill(0);
      v = rq0.pop_front();
      if (v < 256) begin
        bv0 = 1'b1; bi0 = 8'(v);
      end else begin
        gap0 = v - 256 - 1;
      end
    end
  endtask

  task automatic drive_rand1();
    int v;
    bv1 = 1'b0;
    if (gap1 > 0) begin
      gap1--;
    end else begin
      if (rq1.size() == 0) refill(1);
      v = rq1.pop_front();
      if (v < 256) begin
        bv1 = 1'b1; bi1 = 8'(v);
      end else begin
        gap1 = v - 256 - 1;
      end
    end
  endtask

  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_frame_data0", 128'(fd0), 128'd0);
    chk("reset_frame_valid0", 128'(fv0), 128'd0);
    chk("reset_frame_data1", 128'(fd1), 128'd0);
    rst_n = 1'b1;
    tick();

    // address match
    put0(8'h20); put0(8'h12); put0(8'h34);
    chk("t1_valid", 128'(fv0), 128'd1);
    chk("t1_data",  128'(fd0), 128'h201234);
    chk("t1_bcast", 128'(fbc0), 128'd0);
    tick();
    chk("t1_pulse_end", 128'(fv0), 128'd0);

    // non-matching header dropped, then broadcast
    put0(8'h05); put0(8'hAA); put0(8'hBB); put0(8'h00); put0(8'h01);
    chk("t2_no_valid", 128'(fv0), 128'd0);
    put0(8'h02);
    chk("t2_valid", 128'(fv0), 128'd1);
    chk("t2_data",  128'(fd0), 128'h000102);
    chk("t2_bcast", 128'(fbc0), 128'd1);

    // timeout after 400 idle cycles
    put0(8'h20); put0(8'h12);
    repeat (399) tick();
    chk("t3_no_tmo_399", 128'(et0), 128'd0);
    tick();
    chk("t3_tmo", 128'(et0), 128'd1);
    tick();
    chk("t3_tmo_end", 128'(et0), 128'd0);
    put0(8'h20); put0(8'h01); put0(8'h02);
    chk("t3_data", 128'(fd0), 128'h200102);

    // 399-cycle gap inside a frame
    put0(8'h20); put0(8'h12);
    repeat (399) tick();
    put0(8'h34);
    chk("t4_valid", 128'(fv0), 128'd1);
    chk("t4_data",  128'(fd0), 128'h201234);
    chk("t4_tmo_total", 128'(etcnt0), 128'd1);

    // checksum config
    put1(8'h20); put1(8'h11); put1(8'h22); put1(8'h13);
    chk("t5_valid", 128'(fv1), 128'd1);
    chk("t5_data",  128'(fd1), 128'h20112213);
    put1(8'h20); put1(8'h11); put1(8'h22); put1(8'h00);
    chk("t5_cksum_err", 128'(ec1), 128'd1);
    chk("t5_no_valid",  128'(fv1), 128'd0);
    chk("t5_data_held", 128'(fd1), 128'h20112213);

    // back-to-back frames, then reset mid-frame
    base = fvcnt0;
    put0(8'h20); put0(8'h01); put0(8'h02);
    put0(8'h3F); put0(8'h0A); put0(8'h0B);
    chk("t6_data", 128'(fd0), 128'h3F0A0B);
    put0(8'h20); put0(8'h05);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_data",  128'(fd0), 128'd0);
    chk("t6_rst_valid", 128'(fv0), 128'd0);
    chk("t6_rst_bcast", 128'(fbc0), 128'd0);
    chk("t6_two_frames", 128'(fvcnt0 - base), 128'd2);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int n = 0; n < 8000; n++) begin
      drive_rand0();
      drive_rand1();
      tick();
    end
    bv0 = 1'b0; bv1 = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
